m_ff_load_seq: RTL

Upstream load sequencer for the `m_ff` data-path register. It accepts words over a valid/ready interface into a small FIFO. It then drives the register's `enable`/`data_in` pair with single-cycle load pulses, spaced by a programmable minimum gap. This paces register updates independently of producer burstiness.

---
 rtl/m_ff_load_seq_if.sv | 25 ++
 rtl/m_ff_load_seq.sv | 119 +++++++++++
 2 files changed

// File: rtl/m_ff_load_seq_if.sv
// Producer handshake and register-load bus of the m_ff load sequencer.
// The design drives the slave side; the producer/consumer side uses master.
interface m_ff_load_seq_if #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
);
  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH-1:0]           in_data;
  logic                       ld_enable;
  logic [WIDTH-1:0]           ld_data;
  logic [$clog2(DEPTH+1)-1:0] level;
  logic                       busy;

  modport master (
    output flush, in_valid, in_data,
    input  in_ready, ld_enable, ld_data, level, busy
  );

  modport slave (
    input  flush, in_valid, in_data,
    output in_ready, ld_enable, ld_data, level, busy
  );
endinterface

// File: rtl/m_ff_load_seq.sv
// Load sequencer for the m_ff register: a small FIFO plus an FSM that issues
// single-cycle load pulses, spaced by at least GAP idle cycles.
//
// state  | meaning
// IDLE   | no pulse pending; leaves as soon as the FIFO holds a word
// LOAD   | ld_enable high for one cycle with the word popped on entry
// GAP    | forced idle spacing, GAP cycles, timed by a down-counter
module m_ff_load_seq #(
  parameter int               WIDTH     = 12,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               DEPTH     = 4,
  parameter int               GAP       = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  m_ff_load_seq_if.slave  bus
);
  localparam int LW     = $clog2(DEPTH + 1);
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [CW-1:0]    gap_cnt_q;
  logic             ld_enable_q;
  logic [WIDTH-1:0] ld_data_q;
  logic             in_ready;
  logic             push;
  logic             pop;
  logic             gap_load;

  // Ready depends only on registered occupancy, so a full FIFO refuses a
  // word even on the cycle it pops.
  assign in_ready = (level_q != LW'(DEPTH));
  assign push     = bus.in_valid && in_ready && !bus.flush;
  assign pop      = (state_d == S_LOAD);

  always_comb begin
    state_d  = state_q;
    gap_load = 1'b0;
    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (level_q != '0) state_d = S_LOAD;
        end
        S_LOAD: begin
          if (GAP > 0) begin
            state_d  = S_GAP;
            gap_load = 1'b1;
          end else if (level_q != '0) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == '0) state_d = (level_q != '0) ? S_LOAD : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      gap_cnt_q <= '0;
    end else if (bus.flush) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (!push && pop) level_q <= level_q - LW'(1);
      if (gap_load)                                gap_cnt_q <= CW'(GAP_M1);
      else if (state_q == S_GAP && gap_cnt_q != '0) gap_cnt_q <= gap_cnt_q - CW'(1);
    end
  end

  // ld_data is deliberately untouched by flush: the register keeps its word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_enable_q <= 1'b0;
      ld_data_q   <= RESET_VAL;
    end else begin
      ld_enable_q <= pop;
      if (pop) ld_data_q <= mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.in_data;
  end

  assign bus.in_ready  = in_ready;
  assign bus.ld_enable = ld_enable_q;
  assign bus.ld_data   = ld_data_q;
  assign bus.level     = level_q;
  assign bus.busy      = (level_q != '0) || (state_q != S_IDLE);
endmodule
